// File: rtl/imu_sched_if.sv
// -----------------------------------------------------------------------------
// imu_sched_if -- command/response link between the IMU sampling scheduler
// and a byte-level I2C master.
//
//   cmd_valid / cmd_ready   command handshake (scheduler -> master)
//   cmd_op                  0 = single register write, 1 = burst read
//   cmd_dev                 7-bit device address
//   cmd_reg                 start register
//   cmd_wdata               write data byte
//   cmd_len                 burst length in bytes
//   rsp_valid               one read byte presented, or a write completed
//   rsp_data                read byte
//   rsp_last                final response of the transaction
//   rsp_err                 NACK / arbitration loss, qualified by rsp_valid
//
// modport master : the scheduler side (drives cmd_*, receives rsp_*)
// modport slave  : the I2C master side
// -----------------------------------------------------------------------------
interface imu_sched_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_op;
   logic [6:0] cmd_dev;
   logic [7:0] cmd_reg;
   logic [7:0] cmd_wdata;
   logic [3:0] cmd_len;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_last;
   logic       rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_dev, cmd_reg, cmd_wdata, cmd_len,
      input  cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dev, cmd_reg, cmd_wdata, cmd_len,
      output cmd_ready, rsp_valid, rsp_data, rsp_last, rsp_err
   );
endinterface

// File: rtl/imu_sched.sv
// -----------------------------------------------------------------------------
// imu_sched -- configures an I2C IMU with a fixed four-write table, then reads
// a 14-byte burst (accel, temperature, gyro) on every sample tick and publishes
// the 16-bit fields zero-extended to 32 bits.  Errors (NACK, arbitration loss,
// bad burst length, timeout) are counted and followed by a back-off period;
// three read errors in a row force a full reconfiguration.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   enable                run request; dropping it lets the current
//                         transaction finish and then parks in IDLE
//   bus (master)          command/response link to the byte-level I2C master
//   readdata_0..2         accel X/Y/Z
//   readdata_3..5         gyro X/Y/Z
//   readdata_6            temperature
//   sample_cnt            committed samples (wraps)
//   err_cnt               errors (saturates at 255)
//   status                {overrun, configured, busy, data_valid}
// -----------------------------------------------------------------------------
module imu_sched #(
   parameter logic [6:0]  DEV_ADD    = 7'h68,
   parameter int unsigned SAMPLE_DIV = 80000,
   parameter int unsigned TIMEOUT    = 20000,
   parameter int unsigned BACKOFF    = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   imu_sched_if.master bus,
   output logic [31:0] readdata_0,
   output logic [31:0] readdata_1,
   output logic [31:0] readdata_2,
   output logic [31:0] readdata_3,
   output logic [31:0] readdata_4,
   output logic [31:0] readdata_5,
   output logic [31:0] readdata_6,
   output logic [15:0] sample_cnt,
   output logic [7:0]  err_cnt,
   output logic [3:0]  status
);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG_REQ, S_CFG_WAIT, S_ARMED,
      S_RD_REQ, S_RD_COLLECT, S_COMMIT, S_BACKOFF
   } state_t;

   localparam logic [31:0] TICK_LAST = 32'(SAMPLE_DIV - 1);
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);
   localparam logic [31:0] BO_LAST   = 32'(BACKOFF - 1);
   localparam logic [7:0]  RD_REG    = 8'h3B;
   localparam logic [3:0]  RD_LEN    = 4'd14;

   // {register, data} pairs written in order during configuration
   localparam logic [15:0] CFG_TABLE [4] = '{16'h6B00, 16'h1A03, 16'h1B00, 16'h1C00};

   state_t         state, next_state;
   logic [1:0]     cfg_idx;
   logic [3:0]     byte_idx;
   logic [111:0]   rx_buf;
   logic [31:0]    tick_cnt, to_cnt, bo_cnt;
   logic [1:0]     rd_err_cnt;
   logic           configured, data_valid, overrun, err_cfg;
   logic           tick, timed_out, in_txn, busy;
   logic           ev_err, ev_cfg_ok, ev_byte;
   logic           enter_req, to_idle, restart_cfg;

   assign in_txn    = (state == S_CFG_REQ) || (state == S_CFG_WAIT) ||
                      (state == S_RD_REQ)  || (state == S_RD_COLLECT);
   assign busy      = in_txn || (state == S_COMMIT);
   assign timed_out = in_txn && (to_cnt >= TO_LAST);
   assign tick      = configured && (tick_cnt == TICK_LAST);

   // A new transaction starts whenever a request state is entered; its
   // timeout window is measured from that first cmd_valid cycle.
   assign enter_req   = (next_state != state) &&
                        ((next_state == S_CFG_REQ) || (next_state == S_RD_REQ));
   assign to_idle     = (next_state == S_IDLE) && (state != S_IDLE);
   assign restart_cfg = (state == S_BACKOFF) && (next_state == S_CFG_REQ);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      next_state = state;
      ev_err     = 1'b0;
      ev_cfg_ok  = 1'b0;
      ev_byte    = 1'b0;
      case (state)
         S_IDLE:
            if (enable) next_state = S_CFG_REQ;
         S_CFG_REQ, S_RD_REQ:
            // cmd_valid is held until accepted; enable is not consulted here
            if (bus.cmd_ready) next_state = (state == S_CFG_REQ) ? S_CFG_WAIT : S_RD_COLLECT;
            else if (timed_out) ev_err = 1'b1;
         S_CFG_WAIT:
            if (bus.rsp_valid && bus.rsp_err) ev_err = 1'b1;
            else if (bus.rsp_valid && bus.rsp_last) begin
               ev_cfg_ok = 1'b1;
               if (!enable)               next_state = S_IDLE;
               else if (cfg_idx == 2'd3)  next_state = S_ARMED;
               else                       next_state = S_CFG_REQ;
            end else if (timed_out) ev_err = 1'b1;
         S_ARMED:
            if (!enable)   next_state = S_IDLE;
            else if (tick) next_state = S_RD_REQ;
         S_RD_COLLECT:
            if (bus.rsp_valid && bus.rsp_err) ev_err = 1'b1;
            else if (bus.rsp_valid) begin
               ev_byte = 1'b1;
               // the burst must end exactly on its 14th byte
               if (byte_idx == 4'd13 && bus.rsp_last)       next_state = S_COMMIT;
               else if (byte_idx == 4'd13 || bus.rsp_last)  ev_err = 1'b1;
            end else if (timed_out) ev_err = 1'b1;
         S_COMMIT:
            next_state = enable ? S_ARMED : S_IDLE;
         S_BACKOFF:
            if (bo_cnt == BO_LAST) begin
               if (!enable)                             next_state = S_IDLE;
               else if (err_cfg || rd_err_cnt == 2'd3)  next_state = S_CFG_REQ;
               else                                     next_state = S_ARMED;
            end
         default:
            next_state = S_IDLE;
      endcase
      if (ev_err) next_state = S_BACKOFF;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt   <= '0;
         to_cnt     <= '0;
         bo_cnt     <= '0;
         cfg_idx    <= '0;
         byte_idx   <= '0;
         // NOTE: the capture buffer is cleared as well, so no stale sample
         // bytes survive a reset.
         rx_buf     <= '0;
         rd_err_cnt <= '0;
         err_cfg    <= 1'b0;
         configured <= 1'b0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
         err_cnt    <= '0;
         sample_cnt <= '0;
         readdata_0 <= '0;
         readdata_1 <= '0;
         readdata_2 <= '0;
         readdata_3 <= '0;
         readdata_4 <= '0;
         readdata_5 <= '0;
         readdata_6 <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register sees
         // the pre-edge value of every other register.
         tick_cnt <= (!configured || tick) ? '0 : tick_cnt + 32'd1;

         if (enter_req)   to_cnt <= '0;
         else if (in_txn) to_cnt <= to_cnt + 32'd1;
         else             to_cnt <= '0;

         bo_cnt <= (state == S_BACKOFF) ? bo_cnt + 32'd1 : '0;

         if (state == S_IDLE || restart_cfg) cfg_idx <= '0;
         else if (ev_cfg_ok)                 cfg_idx <= cfg_idx + 2'd1;

         if (state == S_RD_REQ && bus.cmd_ready) byte_idx <= '0;
         else if (ev_byte)                       byte_idx <= byte_idx + 4'd1;

         // first byte received ends up in the top octet
         if (ev_byte) rx_buf <= {rx_buf[103:0], bus.rsp_data};

         if (ev_err) begin
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            err_cfg <= (state == S_CFG_REQ) || (state == S_CFG_WAIT);
         end

         if (ev_err && (state == S_RD_REQ || state == S_RD_COLLECT))
            rd_err_cnt <= rd_err_cnt + 2'd1;
         else if (state == S_COMMIT || restart_cfg || to_idle)
            rd_err_cnt <= '0;

         if (state == S_COMMIT) begin
            readdata_0 <= {16'h0, rx_buf[111:96]};
            readdata_1 <= {16'h0, rx_buf[95:80]};
            readdata_2 <= {16'h0, rx_buf[79:64]};
            readdata_6 <= {16'h0, rx_buf[63:48]};
            readdata_3 <= {16'h0, rx_buf[47:32]};
            readdata_4 <= {16'h0, rx_buf[31:16]};
            readdata_5 <= {16'h0, rx_buf[15:0]};
            sample_cnt <= sample_cnt + 16'd1;
         end

         if (to_idle || restart_cfg)                        configured <= 1'b0;
         else if (state == S_CFG_WAIT && next_state == S_ARMED) configured <= 1'b1;

         // clearing on the way to IDLE wins over the commit that precedes it
         if (to_idle || restart_cfg) data_valid <= 1'b0;
         else if (state == S_COMMIT) data_valid <= 1'b1;

         if (!enable || to_idle)            overrun <= 1'b0;
         else if (tick && state != S_ARMED) overrun <= 1'b1;
      end
   end

   always_comb begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 1'b0;
      bus.cmd_dev   = '0;
      bus.cmd_reg   = '0;
      bus.cmd_wdata = '0;
      bus.cmd_len   = '0;
      if (state == S_CFG_REQ) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_dev   = DEV_ADD;
         bus.cmd_reg   = CFG_TABLE[cfg_idx][15:8];
         bus.cmd_wdata = CFG_TABLE[cfg_idx][7:0];
         bus.cmd_len   = 4'd1;
      end else if (state == S_RD_REQ) begin
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = 1'b1;
         bus.cmd_dev   = DEV_ADD;
         bus.cmd_reg   = RD_REG;
         bus.cmd_len   = RD_LEN;
      end
   end

   assign status = {overrun, configured, busy, data_valid};

endmodule

// File: tb/tb_imu_sched.sv
// -----------------------------------------------------------------------------
// tb_imu_sched -- directed bench for imu_sched.  The bench plays the I2C master
// through the interface instance; SAMPLE_DIV=100, TIMEOUT=200, BACKOFF=20.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_imu_sched;

   localparam int unsigned SAMPLE_DIV = 100;
   localparam int unsigned TIMEOUT    = 200;
   localparam int unsigned BACKOFF    = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] readdata_0, readdata_1, readdata_2, readdata_3;
   logic [31:0] readdata_4, readdata_5, readdata_6;
   logic [15:0] sample_cnt;
   logic [7:0]  err_cnt;
   logic [3:0]  status;

   int n_vec = 0;
   int n_bad = 0;

   imu_sched_if bus ();

   imu_sched #(
      .DEV_ADD    (7'h68),
      .SAMPLE_DIV (SAMPLE_DIV),
      .TIMEOUT    (TIMEOUT),
      .BACKOFF    (BACKOFF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .bus        (bus),
      .readdata_0 (readdata_0),
      .readdata_1 (readdata_1),
      .readdata_2 (readdata_2),
      .readdata_3 (readdata_3),
      .readdata_4 (readdata_4),
      .readdata_5 (readdata_5),
      .readdata_6 (readdata_6),
      .sample_cnt (sample_cnt),
      .err_cnt    (err_cnt),
      .status     (status)
   );

   always #5 clk = ~clk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // wait (bounded) for cmd_valid; an expired budget shows up as a failed check
   task automatic wait_cmd(input string tag, input int budget);
      int k = 0;
      while (!bus.cmd_valid && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, " cmd_valid"}, 32'(bus.cmd_valid), 32'h1);
   endtask

   task automatic cfg_write(input string tag, input logic [7:0] rg, input logic [7:0] wd,
                            input bit respond);
      wait_cmd(tag, 400);
      check({tag, " cmd"}, 32'({bus.cmd_op, bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata}),
            32'({1'b0, 7'h68, rg, wd}));
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      if (respond) begin
         bus.rsp_valid = 1'b1;
         bus.rsp_last  = 1'b1;
         @(negedge clk);
         bus.rsp_valid = 1'b0;
         bus.rsp_last  = 1'b0;
      end
   endtask

   task automatic run_config(input string tag, input logic [3:0] exp_status);
      cfg_write({tag, " w0"}, 8'h6B, 8'h00, 1'b1);
      cfg_write({tag, " w1"}, 8'h1A, 8'h03, 1'b1);
      cfg_write({tag, " w2"}, 8'h1B, 8'h00, 1'b1);
      cfg_write({tag, " w3"}, 8'h1C, 8'h00, 1'b1);
      check({tag, " status"}, 32'(status), 32'(exp_status));
   endtask

   // burst read: optional stall of 'hold' cycles, bytes base..base+13,
   // rsp_err on byte err_byte (-1 = none), enable dropped at byte drop_at
   task automatic read_txn(input string tag, input logic [7:0] base, input int err_byte,
                           input int hold, input int drop_at);
      wait_cmd(tag, 300);
      check({tag, " cmd"}, 32'({bus.cmd_op, bus.cmd_dev, bus.cmd_reg, bus.cmd_len}),
            32'({1'b1, 7'h68, 8'h3B, 4'd14}));
      for (int i = 0; i < hold; i++) begin
         check({tag, " stall"},
               32'({bus.cmd_valid, bus.cmd_op, bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata, bus.cmd_len}),
               32'({1'b1, 1'b1, 7'h68, 8'h3B, 8'h00, 4'd14}));
         @(negedge clk);
      end
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (i == drop_at) enable = 1'b0;
         bus.rsp_valid = 1'b1;
         bus.rsp_data  = 8'(base + 8'(i));
         bus.rsp_last  = (i == 13);
         bus.rsp_err   = (i == err_byte);
         @(negedge clk);
         if (i == err_byte) break;
      end
      bus.rsp_valid = 1'b0;
      bus.rsp_last  = 1'b0;
      bus.rsp_err   = 1'b0;
   endtask

   initial begin
      int n;
      int b;

      reset         = 1'b1;
      enable        = 1'b0;
      bus.cmd_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = 8'h00;
      bus.rsp_last  = 1'b0;
      bus.rsp_err   = 1'b0;

      // reset state
      @(negedge clk);
      check("rst status", 32'(status), 32'h0);
      check("rst counts", 32'({sample_cnt, err_cnt}), 32'h0);
      check("rst readdata_0", readdata_0, 32'h0);
      check("rst cmd_valid", 32'(bus.cmd_valid), 32'h0);
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b1;

      // configuration with immediate acks, then armed
      run_config("cfg", 4'b0100);

      // first sample: bytes 01..0E
      read_txn("rd1", 8'h01, -1, 0, -1);
      @(negedge clk);
      check("rd1 readdata_0", readdata_0, 32'h0000_0102);
      check("rd1 readdata_1", readdata_1, 32'h0000_0304);
      check("rd1 readdata_2", readdata_2, 32'h0000_0506);
      check("rd1 readdata_3", readdata_3, 32'h0000_090A);
      check("rd1 readdata_4", readdata_4, 32'h0000_0B0C);
      check("rd1 readdata_5", readdata_5, 32'h0000_0D0E);
      check("rd1 readdata_6", readdata_6, 32'h0000_0708);
      check("rd1 sample_cnt", 32'(sample_cnt), 32'd1);
      check("rd1 status", 32'(status), 32'b0101);

      // second sample: bytes A0..AD
      read_txn("rd2", 8'hA0, -1, 0, -1);
      @(negedge clk);
      check("rd2 readdata_0", readdata_0, 32'h0000_A0A1);
      check("rd2 readdata_2", readdata_2, 32'h0000_A4A5);
      check("rd2 readdata_5", readdata_5, 32'h0000_ACAD);
      check("rd2 readdata_6", readdata_6, 32'h0000_A6A7);
      check("rd2 sample_cnt", 32'(sample_cnt), 32'd2);

      // master stalls 110 cycles: command stable, the tick inside is dropped
      read_txn("stall", 8'h20, -1, 110, -1);
      @(negedge clk);
      check("stall readdata_0", readdata_0, 32'h0000_2021);
      check("stall sample_cnt", 32'(sample_cnt), 32'd3);
      check("stall status", 32'(status), 32'b1101);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         if (bus.cmd_valid) n++;
         @(negedge clk);
      end
      check("no queued read", 32'(n), 32'd0);

      // three read errors in a row force a reconfiguration
      read_txn("err1", 8'h50, 5, 0, -1);
      check("err1 err_cnt", 32'(err_cnt), 32'd1);
      check("err1 readdata_0", readdata_0, 32'h0000_2021);
      read_txn("err2", 8'h50, 5, 0, -1);
      read_txn("err3", 8'h50, 5, 0, -1);
      check("err3 err_cnt", 32'(err_cnt), 32'd3);
      wait_cmd("replay", 300);
      check("replay status", 32'(status), 32'b1010);
      check("replay readdata_6", readdata_6, 32'h0000_2627);
      check("replay readdata_3", readdata_3, 32'h0000_2829);
      check("replay sample_cnt", 32'(sample_cnt), 32'd3);
      run_config("replay", 4'b1100);

      // enable low while armed: to IDLE, flags clear, data and counts hold
      enable = 1'b0;
      @(negedge clk);
      check("idle status", 32'(status), 32'h0);
      check("idle counts", 32'({sample_cnt, err_cnt}), 32'({16'd3, 8'd3}));
      check("idle readdata_0", readdata_0, 32'h0000_2021);

      // config write accepted but never answered: timeout, then backoff
      enable = 1'b1;
      wait_cmd("to", 50);
      n = 0;
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      n++;
      bus.cmd_ready = 1'b0;
      while (err_cnt == 8'd3 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("timeout cycles", 32'(n), 32'(TIMEOUT));
      check("timeout err_cnt", 32'(err_cnt), 32'd4);
      b = 0;
      while (!bus.cmd_valid && b < 100) begin
         b++;
         @(negedge clk);
      end
      check("backoff cycles", 32'(b), 32'(BACKOFF));
      run_config("cfg_to", 4'b0100);

      // enable drops mid-burst: the burst completes, then IDLE
      read_txn("drop", 8'h30, -1, 0, 3);
      @(negedge clk);
      check("drop readdata_0", readdata_0, 32'h0000_3031);
      check("drop readdata_4", readdata_4, 32'h0000_3A3B);
      check("drop sample_cnt", 32'(sample_cnt), 32'd4);
      check("drop status", 32'(status), 32'h0);

      // reset in the middle of a burst clears everything without a clock
      enable = 1'b1;
      run_config("cfg_rst", 4'b0100);
      wait_cmd("rst_rd", 300);
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      bus.cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.rsp_valid = 1'b1;
         bus.rsp_data  = 8'(8'h70 + 8'(i));
         @(negedge clk);
      end
      bus.rsp_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async rst readdata_0", readdata_0, 32'h0);
      check("async rst readdata_6", readdata_6, 32'h0);
      check("async rst counts", 32'({sample_cnt, err_cnt}), 32'h0);
      check("async rst status", 32'(status), 32'h0);
      check("async rst cmd",
            32'({bus.cmd_valid, bus.cmd_op, bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata}), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      wait_cmd("post rst", 50);
      check("post rst cmd", 32'({bus.cmd_op, bus.cmd_dev, bus.cmd_reg, bus.cmd_wdata}),
            32'({1'b0, 7'h68, 8'h6B, 8'h00}));
      check("post rst status", 32'(status), 32'b0010);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
